// File: rtl/veririsc_pkg.sv
// Shared VeriRISC definitions: opcode and phase encodings.
// Used by the controller, mux, ALU, register and memory blocks.
package veririsc_pkg;
    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    localparam logic [2:0] INST_ADDR  = 3'd0;
    localparam logic [2:0] INST_FETCH = 3'd1;
    localparam logic [2:0] INST_LOAD  = 3'd2;
    localparam logic [2:0] IDLE       = 3'd3;
    localparam logic [2:0] OP_ADDR    = 3'd4;
    localparam logic [2:0] OP_FETCH   = 3'd5;
    localparam logic [2:0] ALU_OP     = 3'd6;
    localparam logic [2:0] STORE      = 3'd7;
endpackage

// File: rtl/controller_counter.sv
// 3-bit wrapping phase counter with async reset and count enable.
module counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [2:0] cnt
);
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = cnt_q + 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 3'd0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/controller.sv
// VeriRISC eight-phase sequencer: phase counter plus strobe decode.
module controller
    import veririsc_pkg::*;
#(
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       halt,
    output logic       ld_pc,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr,
    output logic [2:0] phase
);
    logic [2:0] phase_q;
    logic       halted_q;
    logic       halted_d;
    logic       aluop;

    // The set term also gates the counter so the phase freezes at OP_ADDR.
    always_comb begin
        halted_d = halted_q;
        if (HALT_STICKY && phase_q == OP_ADDR && opcode == HLT)
            halted_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) halted_q <= 1'b0;
        else     halted_q <= halted_d;
    end

    counter u_counter (
        .clk (clk),
        .rst (rst),
        .en  (~halted_d),
        .cnt (phase_q)
    );

    assign aluop = (opcode == ADD) || (opcode == AND) ||
                   (opcode == XOR) || (opcode == LDA);

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            unique case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == SKZ) && zero;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    inc_pc = (opcode == JMP);
                    ld_pc  = (opcode == JMP);
                    wr     = (opcode == STO);
                    data_e = (opcode == STO);
                end
                default: ;
            endcase
        end
    end

    assign phase = phase_q;
endmodule

// File: doc/controller.md
# controller

Eight-phase instruction sequencer for the VeriRISC CPU. It steps a 3-bit phase counter through fetch and execute and decodes the phase plus the 3-bit opcode from the instruction register into the datapath strobes. One of those strobes, `sel`, drives the address mux directly upstream of memory. `sel=1` selects the PC address (mux `in1`); `sel=0` selects the IR operand address (mux `in0`).

## Interface
- `HALT_STICKY`, default 1: 1 = once `halt` asserts, hold it and freeze the phase until reset; 0 = phase keeps cycling and `halt` is a one-phase pulse.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `opcode` input 3: IR opcode. HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `zero` input 1: accumulator-is-zero flag from the ALU.
- `sel` output 1: address mux select (1 = PC).
- `rd` output 1: memory read.
- `ld_ir` output 1: load instruction register.
- `inc_pc` output 1: increment PC.
- `halt` output 1: CPU halted.
- `ld_pc` output 1: load PC from IR address.
- `data_e` output 1: enable the data bus driver toward memory.
- `ld_ac` output 1: load accumulator.
- `wr` output 1: memory write.
- `phase` output 3: current phase, for debug and bench.

## Operation
- Phases 0 to 7: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
- Phase advances by +1 every clock and wraps from 7 to 0.
- Decode terms:
  - ALUOP = ADD | AND | XOR | LDA.
  - HLT, SKZ, JMP and STO are single-opcode compares.
- Strobes are 1 only where listed; everything else is 0.
  - INST_ADDR: `sel`.
  - INST_FETCH: `sel`, `rd`.
  - INST_LOAD: `sel`, `rd`, `ld_ir`.
  - IDLE: `sel`, `rd`, `ld_ir`.
  - OP_ADDR: `inc_pc`; `halt` = HLT.
  - OP_FETCH: `rd` = ALUOP.
  - ALU_OP: `rd` = ALUOP; `inc_pc` = SKZ & `zero`; `ld_pc` = JMP; `data_e` = STO.
  - STORE: `rd` = ALUOP; `ld_ac` = ALUOP; `inc_pc` = JMP; `ld_pc` = JMP; `wr` = STO; `data_e` = STO.
- Halt state, when `HALT_STICKY`=1:
  - Set on the clock edge that ends OP_ADDR with opcode=HLT.
  - While set: phase holds at OP_ADDR (4), `halt`=1, and every other strobe is 0.
  - `opcode` and `zero` are ignored.
  - Only `rst` clears it.
- `wr` and `data_e` are never 1 in the same phase as `rd`. The bench asserts this.

## Timing
- Reset, asynchronous: phase=0 and the halt flag is cleared immediately, without waiting for a clock edge.
  - Output values under reset: `sel`=1, `phase`=0, all other outputs 0.
  - The first edge after `rst` deasserts moves phase to 1.
  - Reset mid-instruction abandons that instruction; no strobe is held over.
- Strobes are combinational from registered phase plus the `opcode`/`zero` inputs, so they are valid in the same cycle as the phase.
  - `opcode` must be stable from IDLE through STORE. It is loaded during INST_LOAD/IDLE.
  - `zero` is sampled only during ALU_OP.
- One instruction takes exactly 8 clocks.
- SKZ with `zero`=1 gives an extra `inc_pc` in ALU_OP, i.e. two increments per instruction.
- JMP asserts `ld_pc` in both ALU_OP and STORE. `inc_pc` also asserts in STORE; the PC gives load priority.
- In halt, `halt` rises at OP_ADDR of the HLT instruction and stays 1.

## Structure
- Shared package `veririsc_pkg` holds:
  - opcode constants HLT..JMP (3 bits);
  - phase constants INST_ADDR..STORE (3 bits).
- The mux, ALU, register and memory blocks reuse the same package.
- One natural sub-module: `counter`, a 3-bit wrapping counter with async reset and a count enable. It is driven with enable = ~halted.
- The decode is a combinational case on phase inside `controller`.

## Test plan
- Reset: assert `rst`=1 mid-cycle.
  - Required: `phase`=0 immediately, `sel`=1, all else 0.
  - After release, `phase` steps 1,2,…,7,0 on successive edges.
- ADD (opcode=2) through one 8-cycle instruction.
  - Required: `rd`=1 in phases 1,2,3,5,6,7; `ld_ir`=1 in 2,3; `inc_pc`=1 in 4 only; `ld_ac`=1 in 7 only; `wr`=0 throughout.
- STO (opcode=6).
  - Required: `data_e`=1 in phases 6,7; `wr`=1 in 7 only; `rd`=0 in 5,6,7.
- SKZ (opcode=1).
  - With `zero`=1: `inc_pc`=1 in phases 4 and 6.
  - With `zero`=0: `inc_pc`=1 in phase 4 only.
- JMP (opcode=7).
  - Required: `ld_pc`=1 in phases 6,7; `inc_pc`=1 in 4,7.
- HLT (opcode=0) with `HALT_STICKY`=1.
  - Required: `halt`=1 from phase 4; `phase` frozen at 4 for ≥20 clocks; all other strobes 0.
  - A following `rst` pulse returns `phase` to 0 with `halt`=0.
